regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among three writeback sources: ALU result (req 0), memory load (req 1) and link/channel input (req 2).
- Grants one source per cycle using round-robin priority.
- Drives registered RD (4-bit register select, one-hot expanded by WriteDecoder), write data and write enable.
- Sits between the execute/memory stages and the register file / WriteDecoder pair.

Parameters:
DATA_WIDTH, 16, width of write data.
ADDR_WIDTH, 4, width of register select (RD); 2**ADDR_WIDTH registers.
CNT_WIDTH, 8, width of completed-write counter.

Ports:
CLK  input  1  single system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
hold  input  1  freeze: no new grants while high.
req  input  3  request per source; bit i = source i.
rd0, rd1, rd2  input  ADDR_WIDTH each  destination register of source i.
data0, data1, data2  input  DATA_WIDTH each  write value of source i.
gnt  output  3  one-hot grant pulse, one cycle, combinational from state and req.
WrEn  output  1  registered write enable to register file.
RD  output  ADDR_WIDTH  registered register select to WriteDecoder.
WrData  output  DATA_WIDTH  registered write data.
wr_count  output  CNT_WIDTH  number of completed writes.
busy  output  1  high when any req bit is high and hold is low.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - WrEn=0, RD=0, WrData=0, wr_count=0.
  - Round-robin pointer ptr=0, meaning source 0 has highest priority next.
  - gnt=0 while Reset is high.
- Handshake:
  - A source raises req[i] and holds req/rd/data stable until it sees gnt[i]=1 at a rising edge.
  - It may drop req on the following cycle or keep it high for another write.
  - A req dropped before it is granted is legal; nothing is written for that source.
- Arbitration (combinational):
  - Search order starts at ptr: ptr, ptr+1, ptr+2, mod 3. The first set req bit is granted.
  - No grant when hold=1 or req=0.
  - At most one gnt bit is high.
- Grant register update, at the edge where gnt[i]=1:
  - WrEn<=1, RD<=rdi, WrData<=datai, ptr<=(i+1) mod 3, wr_count<=wr_count+1.
  - wr_count wraps modulo 2**CNT_WIDTH (255 -> 0).
- No-grant edge: WrEn<=0. RD, WrData and ptr hold their values.
- Latency: request seen in cycle N with grant in cycle N gives WrEn/RD/WrData valid in cycle N+1. Back-to-back grants give one write per cycle.
- Writes to RD=0 are not special here; the register file owns R0 semantics.
- Two sources targeting the same register:
  - Served in arbitration order, one per cycle. The later write wins.
  - No merging and no dropping.
- hold:
  - Rising hold suppresses the grant in that same cycle.
  - An already-registered write (WrEn=1) still completes on its cycle.
  - Deasserting hold resumes arbitration from the unchanged ptr.
- ptr must never reach 3. If it does (SEU or bad init), treat it as 0.
- busy = |req & ~hold. It is combinational and purely informational.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, req=0 -> WrEn=0, RD=0, WrData=0, wr_count=0, gnt=000 throughout.
- Single source: req=001, rd0=5, data0=16'hBEEF for one cycle -> gnt=001 that cycle. Next cycle WrEn=1, RD=5, WrData=BEEF, wr_count=1. Following cycle WrEn=0.
- Round-robin fairness: req=111 held 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100. wr_count=6. RD tracks rd0/rd1/rd2 accordingly.
- Same destination:
  - Setup: req=011, rd0=rd1=7, data0=0x0001, data1=0x0002, ptr=0.
  - Response: writes RD=7/0x0001, then RD=7/0x0002 on consecutive cycles.
- Hold: req=111 with hold=1 for 3 cycles -> gnt=000, WrEn=0 after the pending write drains, ptr unchanged. Releasing hold grants the source at the prior ptr first.
- Async reset mid-stream and wrap:
  - Reset pulse asserted between edges during req=111 -> outputs clear immediately. After release, first gnt=001.
  - Separately, 256 grants -> wr_count returns to 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle shared by the three writeback sources, the arbiter and the
// register file / WriteDecoder pair.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  hold;
    logic [2:0]            req;
    logic [ADDR_WIDTH-1:0] rd0;
    logic [ADDR_WIDTH-1:0] rd1;
    logic [ADDR_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [2:0]            gnt;
    logic                  busy;
    logic                  WrEn;
    logic [ADDR_WIDTH-1:0] RD;
    logic [DATA_WIDTH-1:0] WrData;
    logic [CNT_WIDTH-1:0]  wr_count;

    // Sources and register-file side.
    modport master (
        output hold, req, rd0, rd1, rd2, data0, data1, data2,
        input  gnt, busy, WrEn, RD, WrData, wr_count
    );

    // Arbiter side.
    modport slave (
        input  hold, req, rd0, rd1, rd2, data0, data1, data2,
        output gnt, busy, WrEn, RD, WrData, wr_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU (0),
// load (1) and link (2) writeback sources; write port outputs are registered.
//
//   ptr | meaning
//   ----+--------------------------------------------
//    0  | source 0 has highest priority (then 1, 2)
//    1  | source 1 has highest priority (then 2, 0)
//    2  | source 2 has highest priority (then 0, 1)
//    3  | illegal (upset / bad init), behaves as 0
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   CLK,
    input  logic                   Reset,
    regfile_write_arbiter_if.slave bus
);

    logic [1:0]            ptr;
    logic [1:0]            ptr_eff;
    logic [1:0]            gnt_idx;
    logic                  gnt_any;
    logic [2:0]            gnt_c;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [CNT_WIDTH-1:0]  wr_count_q;

    assign ptr_eff = (ptr == 2'd3) ? 2'd0 : ptr;

    // First requester found in rotating order starting at ptr wins.
    always_comb begin
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        if (!Reset && !bus.hold) begin
            case (ptr_eff)
                2'd1: begin
                    if (bus.req[1]) begin
                        gnt_idx = 2'd1; gnt_any = 1'b1;
                    end else if (bus.req[2]) begin
                        gnt_idx = 2'd2; gnt_any = 1'b1;
                    end else if (bus.req[0]) begin
                        gnt_idx = 2'd0; gnt_any = 1'b1;
                    end
                end
                2'd2: begin
                    if (bus.req[2]) begin
                        gnt_idx = 2'd2; gnt_any = 1'b1;
                    end else if (bus.req[0]) begin
                        gnt_idx = 2'd0; gnt_any = 1'b1;
                    end else if (bus.req[1]) begin
                        gnt_idx = 2'd1; gnt_any = 1'b1;
                    end
                end
                default: begin
                    if (bus.req[0]) begin
                        gnt_idx = 2'd0; gnt_any = 1'b1;
                    end else if (bus.req[1]) begin
                        gnt_idx = 2'd1; gnt_any = 1'b1;
                    end else if (bus.req[2]) begin
                        gnt_idx = 2'd2; gnt_any = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        gnt_c = 3'b000;
        if (gnt_any) begin
            gnt_c = 3'b001 << gnt_idx;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ptr        <= 2'd0;
            wr_en_q    <= 1'b0;
            rd_q       <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
        end else if (gnt_any) begin
            wr_en_q    <= 1'b1;
            wr_count_q <= wr_count_q + CNT_WIDTH'(1);
            ptr        <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            case (gnt_idx)
                2'd1: begin
                    rd_q      <= bus.rd1;
                    wr_data_q <= bus.data1;
                end
                2'd2: begin
                    rd_q      <= bus.rd2;
                    wr_data_q <= bus.data2;
                end
                default: begin
                    rd_q      <= bus.rd0;
                    wr_data_q <= bus.data0;
                end
            endcase
        end else begin
            wr_en_q <= 1'b0;
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.busy     = (|bus.req) & ~bus.hold;
    assign bus.WrEn     = wr_en_q;
    assign bus.RD       = rd_q;
    assign bus.WrData   = wr_data_q;
    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, round-robin,
// same-destination ordering, hold, async reset mid-stream and counter wrap.
module tb_regfile_write_arbiter;

    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_pass;
    logic [7:0] exp_cnt;

    regfile_write_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CNT_WIDTH(8)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CNT_WIDTH(8)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 3'b000;
        Reset   = 1'b1;
        tick();
        tick();
        Reset   = 1'b0;
        exp_cnt = 8'd0;
        #1;
    endtask

    task automatic test_reset();
        bus.hold = 1'b0; bus.req = 3'b000;
        bus.rd0 = 4'd0; bus.rd1 = 4'd0; bus.rd2 = 4'd0;
        bus.data0 = 16'h0; bus.data1 = 16'h0; bus.data2 = 16'h0;
        Reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (bus.gnt !== 3'b000) $display("FAIL reset_gnt cyc%0d: got %b want 000", c, bus.gnt);
            else n_pass++;
        end
        n_checks++;
        if (bus.WrEn !== 1'b0) $display("FAIL reset_wren: got %b want 0", bus.WrEn); else n_pass++;
        n_checks++;
        if (bus.RD !== 4'd0) $display("FAIL reset_rd: got %0d want 0", bus.RD); else n_pass++;
        n_checks++;
        if (bus.WrData !== 16'h0) $display("FAIL reset_wrdata: got %h want 0000", bus.WrData); else n_pass++;
        n_checks++;
        if (bus.wr_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.wr_count); else n_pass++;
        Reset = 1'b0;
        exp_cnt = 8'd0;
        tick();
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.WrEn !== 1'b0)
            $display("FAIL idle: gnt %b wren %b want 000/0", bus.gnt, bus.WrEn);
        else n_pass++;
    endtask

    task automatic test_single();
        bus.req = 3'b001; bus.rd0 = 4'd5; bus.data0 = 16'hBEEF;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b001) $display("FAIL single_gnt: got %b want 001", bus.gnt); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++;
        tick();
        bus.req = 3'b000;
        exp_cnt = exp_cnt + 8'd1;
        #1;
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RD !== 4'd5 || bus.WrData !== 16'hBEEF)
            $display("FAIL single_write: wren %b rd %0d data %h want 1/5/beef", bus.WrEn, bus.RD, bus.WrData);
        else n_pass++;
        n_checks++;
        if (bus.wr_count !== exp_cnt) $display("FAIL single_count: got %0d want %0d", bus.wr_count, exp_cnt); else n_pass++;
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.busy !== 1'b0)
            $display("FAIL single_idle_gnt: gnt %b busy %b want 000/0", bus.gnt, bus.busy);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.WrEn !== 1'b0 || bus.RD !== 4'd5 || bus.WrData !== 16'hBEEF)
            $display("FAIL single_after: wren %b rd %0d data %h want 0/5/beef", bus.WrEn, bus.RD, bus.WrData);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [3:0]  exp_rd  [6] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
        logic [15:0] exp_dat [6] = '{16'hA000, 16'hB111, 16'hC222, 16'hA000, 16'hB111, 16'hC222};
        do_reset();
        bus.rd0 = 4'd1; bus.rd1 = 4'd2; bus.rd2 = 4'd3;
        bus.data0 = 16'hA000; bus.data1 = 16'hB111; bus.data2 = 16'hC222;
        bus.req = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (bus.gnt !== exp_gnt[k]) $display("FAIL rr_gnt%0d: got %b want %b", k, bus.gnt, exp_gnt[k]);
            else n_pass++;
            tick();
            exp_cnt = exp_cnt + 8'd1;
            n_checks++;
            if (bus.WrEn !== 1'b1 || bus.RD !== exp_rd[k] || bus.WrData !== exp_dat[k])
                $display("FAIL rr_write%0d: wren %b rd %0d data %h want 1/%0d/%h",
                         k, bus.WrEn, bus.RD, bus.WrData, exp_rd[k], exp_dat[k]);
            else n_pass++;
        end
        bus.req = 3'b000;
        n_checks++;
        if (bus.wr_count !== 8'd6) $display("FAIL rr_count: got %0d want 6", bus.wr_count); else n_pass++;
        tick();
    endtask

    task automatic test_same_dest();
        bus.rd0 = 4'd7; bus.rd1 = 4'd7; bus.data0 = 16'h0001; bus.data1 = 16'h0002;
        bus.req = 3'b011;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b001) $display("FAIL same_gnt0: got %b want 001", bus.gnt); else n_pass++;
        tick();
        bus.req = 3'b010;
        exp_cnt = exp_cnt + 8'd1;
        #1;
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RD !== 4'd7 || bus.WrData !== 16'h0001)
            $display("FAIL same_w0: wren %b rd %0d data %h want 1/7/0001", bus.WrEn, bus.RD, bus.WrData);
        else n_pass++;
        n_checks++;
        if (bus.gnt !== 3'b010) $display("FAIL same_gnt1: got %b want 010", bus.gnt); else n_pass++;
        tick();
        bus.req = 3'b000;
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RD !== 4'd7 || bus.WrData !== 16'h0002)
            $display("FAIL same_w1: wren %b rd %0d data %h want 1/7/0002", bus.WrEn, bus.RD, bus.WrData);
        else n_pass++;
        n_checks++;
        if (bus.wr_count !== exp_cnt) $display("FAIL same_count: got %0d want %0d", bus.wr_count, exp_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_hold();
        // ptr is now 2: grant source 2, then raise hold while its write is pending
        bus.rd2 = 4'd9; bus.data2 = 16'h9999; bus.rd0 = 4'd4; bus.data0 = 16'h4444;
        bus.req = 3'b111;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b100) $display("FAIL hold_pre_gnt: got %b want 100", bus.gnt); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        bus.hold = 1'b1;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.busy !== 1'b0)
            $display("FAIL hold_gnt_rise: gnt %b busy %b want 000/0", bus.gnt, bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RD !== 4'd9 || bus.WrData !== 16'h9999)
            $display("FAIL hold_drain: wren %b rd %0d data %h want 1/9/9999", bus.WrEn, bus.RD, bus.WrData);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.gnt !== 3'b000 || bus.WrEn !== 1'b0 || bus.wr_count !== exp_cnt)
                $display("FAIL hold_cyc%0d: gnt %b wren %b count %0d want 000/0/%0d",
                         c, bus.gnt, bus.WrEn, bus.wr_count, exp_cnt);
            else n_pass++;
        end
        bus.hold = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b001) $display("FAIL hold_release_gnt: got %b want 001", bus.gnt); else n_pass++;
        tick();
        bus.req = 3'b000;
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RD !== 4'd4 || bus.wr_count !== exp_cnt)
            $display("FAIL hold_release_w: wren %b rd %0d count %0d want 1/4/%0d", bus.WrEn, bus.RD, bus.wr_count, exp_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        // ptr is now 1
        bus.rd1 = 4'd6; bus.data1 = 16'h6666;
        bus.req = 3'b111;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b010) $display("FAIL areset_pre_gnt: got %b want 010", bus.gnt); else n_pass++;
        tick();
        n_checks++;
        if (bus.WrEn !== 1'b1 || bus.RD !== 4'd6) $display("FAIL areset_pre_w: wren %b rd %0d want 1/6", bus.WrEn, bus.RD);
        else n_pass++;
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (bus.WrEn !== 1'b0 || bus.RD !== 4'd0 || bus.WrData !== 16'h0 || bus.wr_count !== 8'd0 || bus.gnt !== 3'b000)
            $display("FAIL areset_clear: wren %b rd %0d data %h count %0d gnt %b want all zero",
                     bus.WrEn, bus.RD, bus.WrData, bus.wr_count, bus.gnt);
        else n_pass++;
        tick();
        Reset = 1'b0;
        exp_cnt = 8'd0;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b001) $display("FAIL areset_first_gnt: got %b want 001", bus.gnt); else n_pass++;
        tick();
        bus.req = 3'b000;
        n_checks++;
        if (bus.RD !== 4'd4 || bus.wr_count !== 8'd1)
            $display("FAIL areset_first_w: rd %0d count %0d want 4/1", bus.RD, bus.wr_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 3'b001;
        for (int k = 0; k < 255; k++) tick();
        n_checks++;
        if (bus.wr_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", bus.wr_count); else n_pass++;
        tick();
        bus.req = 3'b000;
        n_checks++;
        if (bus.wr_count !== 8'd0 || bus.WrEn !== 1'b1)
            $display("FAIL wrap_0: count %0d wren %b want 0/1", bus.wr_count, bus.WrEn);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.WrEn !== 1'b0 || bus.wr_count !== 8'd0)
            $display("FAIL wrap_idle: wren %b count %0d want 0/0", bus.WrEn, bus.wr_count);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_cnt  = 8'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_same_dest();
        test_hold();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
